word_receiver: RTL and testbench

//  Serial receive counterpart of the word transmit path: recovers 8N1 ASCII frames from a line

---
 rtl/word_pkg.sv | 23 ++
 rtl/word_receiver_if.sv | 27 ++
 rtl/char_fifo.sv | 54 +++++
 rtl/word_receiver.sv | 197 +++++++++++++++++++
 tb/tb_word_receiver.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/word_pkg.sv
// rtl/word_pkg.sv - shared receiver types and serial/ASCII constants
// Purpose: FSM state encoding, frame constants and terminator helper for word_receiver.
// Ports: none (package).
package word_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam int         DATA_BITS = 8;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  function automatic logic is_terminator(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/word_receiver_if.sv
// rtl/word_receiver_if.sv - FIFO read side and event pulses of word_receiver
// Purpose: bundles the character read port and per-frame status pulses.
// Ports (signals): rd_en, rd_data[7:0], empty, full, char_valid, frame_err,
//   overflow, word_end, word_len[5:0].
//   master: receiver side (drives data/status, reads rd_en).
//   slave:  consumer side (drives rd_en).
interface word_receiver_if;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       char_valid;
  logic       frame_err;
  logic       overflow;
  logic       word_end;
  logic [5:0] word_len;

  modport master (
    input  rd_en,
    output rd_data, empty, full, char_valid, frame_err, overflow, word_end, word_len
  );

  modport slave (
    output rd_en,
    input  rd_data, empty, full, char_valid, frame_err, overflow, word_end, word_len
  );
endinterface

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - synchronous first-word-fall-through character FIFO
// Purpose: 2**DEPTH_LOG2 entry FIFO; push and pop may coincide in any state, incl. full.
// Ports: clk, rst_n (sync, active low), push, push_data[WIDTH-1:0], pop,
//   head[WIDTH-1:0] (zero when empty), full, empty.
module char_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_pop;
  logic                  do_push;

  assign empty   = (count == '0);
  // count never exceeds DEPTH, so its MSB alone marks full
  assign full    = count[DEPTH_LOG2];
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/word_receiver.sv
// rtl/word_receiver.sv - serial 8N1 word receiver with character FIFO
// Purpose: recovers LSB-first serial frames from rx, buffers characters, flags
//   CR/LF word terminators and tracks the current word length.
// Ports: sysclk, rst_n (sync, active low), rx (async serial, idle high),
//   bus (word_receiver_if.master: rd_en in; rd_data, empty, full, char_valid,
//   frame_err, overflow, word_end, word_len out).
// Option: RX_PARITY_EN selects 8E1 framing with even-parity checking.
module word_receiver
  import word_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic            sysclk,
  input  logic            rst_n,
  input  logic            rx,
  word_receiver_if.master bus
);
  localparam int             CW        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_START     = START;
  localparam logic [2:0] ST_DATA      = DATA;
  localparam logic [2:0] ST_STOP      = STOP;
  localparam logic [2:0] ST_WAIT_IDLE = WAIT_IDLE;
`ifdef RX_PARITY_EN
  localparam logic [2:0] ST_PARITY    = PARITY;
`endif

  logic          sync1;
  logic          sync2;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cmt;
  logic          par_bad;
  logic          bit_tick;
  logic          half_tick;

  logic          is_term;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop_req;
  logic          push_ok;

  logic          char_valid_r;
  logic          frame_err_r;
  logic          overflow_r;
  logic          word_end_r;
  logic [5:0]    word_len_r;

  assign bit_tick  = (cnt == BIT_LAST);
  assign half_tick = (cnt == HALF_LAST);

`ifdef RX_PARITY_EN
  logic par_bit;
  assign par_bad = (^shreg) ^ par_bit;
`else
  assign par_bad = 1'b0;
`endif

  // Synchronizer, bit timer and frame FSM
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      cmt         <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      sync1       <= rx;
      sync2       <= sync1;
      cmt         <= 1'b0;
      frame_err_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!sync2) state <= ST_START;
        end
        ST_START: begin
          if (half_tick) begin
            cnt     <= '0;
            bit_idx <= '0;
            // line back high at mid-start means a glitch, not a frame
            state   <= sync2 ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            cnt   <= '0;
            shreg <= {sync2, shreg[7:1]};
            if (bit_idx == LAST_BIT) begin
`ifdef RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef RX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            cnt     <= '0;
            par_bit <= sync2;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            if (!sync2) begin
              frame_err_r <= 1'b1;
              state       <= ST_WAIT_IDLE;
            end else begin
              frame_err_r <= par_bad;
              cmt         <= !par_bad;
              state       <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          // a held-low line (break) must not look like a new start bit
          if (sync2) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Commit: the cycle after a good stop bit, shreg still holds the byte
  assign is_term = is_terminator(shreg);
  assign pop_req = bus.rd_en && !fifo_empty;
  assign push_ok = cmt && !is_term && (!fifo_full || pop_req);

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      char_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      word_end_r   <= 1'b0;
      word_len_r   <= '0;
    end else begin
      char_valid_r <= push_ok;
      overflow_r   <= cmt && !is_term && fifo_full && !pop_req;
      word_end_r   <= cmt && is_term;
      // word_len holds the final count during the word_end cycle, then clears
      if (word_end_r) begin
        word_len_r <= '0;
      end else if (push_ok && (word_len_r != 6'd63)) begin
        word_len_r <= word_len_r + 1'b1;
      end
    end
  end

  char_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clk       (sysclk),
    .rst_n     (rst_n),
    .push      (push_ok),
    .push_data (shreg),
    .pop       (bus.rd_en),
    .head      (bus.rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.empty      = fifo_empty;
  assign bus.full       = fifo_full;
  assign bus.char_valid = char_valid_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.overflow   = overflow_r;
  assign bus.word_end   = word_end_r;
  assign bus.word_len   = word_len_r;
endmodule

// File: tb/tb_word_receiver.sv
// tb/tb_word_receiver.sv - scoreboard bench for word_receiver (CLKS_PER_BIT=16)
// Purpose: directed frames; expected events queued at send time, popped by a monitor.
// Ports: none. Honours RX_PARITY_EN for 8E1 framing.
module tb_word_receiver;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  localparam int K_CHAR = 0;
  localparam int K_WEND = 1;
  localparam int K_FERR = 2;
  localparam int K_OVF  = 3;

  typedef struct {
    int kind;
    int len;
  } ev_t;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  logic rx     = 1'b1;

  word_receiver_if bus ();

  word_receiver #(
    .CLKS_PER_BIT (CPB),
    .DEPTH_LOG2   (4)
  ) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .rx     (rx),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  int         checks = 0;
  int         passes = 0;
  ev_t        exp_q[$];
  logic [7:0] mq[$];
  int         wl = 0;
  logic       prev_wend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic got_ev(input int kind, input int len);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind %0d len %0d expected none", kind, len);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.len == len) passes++;
      else $display("FAIL event: got kind %0d len %0d expected kind %0d len %0d",
                    kind, len, e.kind, e.len);
    end
  endtask

  // Monitor: every pulse consumes one expected event
  always @(negedge sysclk) begin
    if (rst_n) begin
      if (prev_wend) chk("word_len_clear", {26'd0, bus.word_len}, 32'd0);
      prev_wend = bus.word_end;
      if (bus.char_valid) got_ev(K_CHAR, int'(bus.word_len));
      if (bus.word_end)   got_ev(K_WEND, int'(bus.word_len));
      if (bus.frame_err)  got_ev(K_FERR, int'(bus.word_len));
      if (bus.overflow)   got_ev(K_OVF,  int'(bus.word_len));
    end
  end

  task automatic do_reset();
    @(negedge sysclk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge sysclk);
    exp_q.delete();
    mq.delete();
    wl        = 0;
    prev_wend = 1'b0;
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    chk("rst_word_len", {26'd0, bus.word_len}, 32'd0);
    chk("rst_pulses", {28'd0, bus.char_valid, bus.frame_err, bus.overflow, bus.word_end}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit,
                           input logic bad_par, input logic pop_at_commit);
    logic [7:0] exp_pop;
    exp_pop = 8'h00;
    if (!stop_bit || (bad_par && PB == 1)) begin
      exp_q.push_back('{K_FERR, wl});
    end else if (d == 8'h0D || d == 8'h0A) begin
      exp_q.push_back('{K_WEND, wl});
      wl = 0;
    end else if (mq.size() < 16 || pop_at_commit) begin
      if (pop_at_commit && mq.size() > 0) exp_pop = mq.pop_front();
      mq.push_back(d);
      if (wl < 63) wl++;
      exp_q.push_back('{K_CHAR, wl});
    end else begin
      exp_q.push_back('{K_OVF, wl});
    end
    fork
      begin
        @(negedge sysclk);
        rx = 1'b0;
        repeat (CPB) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
          rx = d[i];
          repeat (CPB) @(negedge sysclk);
        end
        if (PB == 1) begin
          rx = (^d) ^ bad_par;
          repeat (CPB) @(negedge sysclk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge sysclk);
        if (stop_bit) begin
          rx = 1'b1;
          repeat (CPB) @(negedge sysclk);
        end
      end
      begin
        // raise rd_en in exactly the commit cycle of this frame
        if (pop_at_commit) begin
          repeat (4 + HALF + (9 + PB) * CPB) @(negedge sysclk);
          chk("commit_pop_data", {24'd0, bus.rd_data}, {24'd0, exp_pop});
          bus.rd_en = 1'b1;
          @(negedge sysclk);
          bus.rd_en = 1'b0;
        end
      end
    join
  endtask

  task automatic read_check(input string name);
    logic [7:0] e;
    @(negedge sysclk);
    chk({name, "_not_empty"}, {31'd0, bus.empty}, 32'd0);
    if (mq.size() > 0) begin
      e = mq.pop_front();
      chk({name, "_data"}, {24'd0, bus.rd_data}, {24'd0, e});
    end
    bus.rd_en = 1'b1;
    @(negedge sysclk);
    bus.rd_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge sysclk);
      n++;
    end
    repeat (2) @(negedge sysclk);
    chk({name, "_events_seen"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.rd_en = 1'b0;

    // 1: single char
    do_reset();
    send_byte(8'h41, 1'b1, 1'b0, 1'b0);
    drain("t1");
    read_check("t1_rd");
    @(negedge sysclk);
    chk("t1_empty_after_rd", {31'd0, bus.empty}, 32'd1);

    // 2: "HI\r" then LF back-to-back
    do_reset();
    send_byte(8'h48, 1'b1, 1'b0, 1'b0);
    send_byte(8'h49, 1'b1, 1'b0, 1'b0);
    send_byte(8'h0D, 1'b1, 1'b0, 1'b0);
    send_byte(8'h0A, 1'b1, 1'b0, 1'b0);
    drain("t2");
    read_check("t2_rd_h");
    read_check("t2_rd_i");
    @(negedge sysclk);
    chk("t2_empty", {31'd0, bus.empty}, 32'd1);

    // 3: short low glitch then a clean char
    do_reset();
    @(negedge sysclk);
    rx = 1'b0;
    repeat (5) @(negedge sysclk);
    rx = 1'b1;
    repeat (40) @(negedge sysclk);
    chk("t3_glitch_empty", {31'd0, bus.empty}, 32'd1);
    send_byte(8'h33, 1'b1, 1'b0, 1'b0);
    drain("t3");
    read_check("t3_rd");

    // 4: bad stop bit, line held low, then clean char
    do_reset();
    send_byte(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge sysclk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge sysclk);
    chk("t4_no_push", {31'd0, bus.empty}, 32'd1);
    send_byte(8'h31, 1'b1, 1'b0, 1'b0);
    drain("t4");
    read_check("t4_rd");

    // 5: fill, overflow, then push+pop while full
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'h61 + 8'(i), 1'b1, 1'b0, 1'b0);
    drain("t5_fill");
    chk("t5_full", {31'd0, bus.full}, 32'd1);
    send_byte(8'h7E, 1'b1, 1'b0, 1'b0);
    drain("t5_ovf");
    send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
    send_byte(8'h23, 1'b1, 1'b0, 1'b1);
    drain("t5_pushpop");
    chk("t5_still_full", {31'd0, bus.full}, 32'd1);
    for (int i = 0; i < 16; i++) read_check("t5_rd");
    @(negedge sysclk);
    chk("t5_empty", {31'd0, bus.empty}, 32'd1);

    // 6: reset mid DATA, then clean frame
    do_reset();
    send_byte(8'h51, 1'b1, 1'b0, 1'b0);
    drain("t6_pre");
    @(negedge sysclk);
    rx = 1'b0;
    repeat (60) @(negedge sysclk);
    rst_n = 1'b0;
    @(negedge sysclk);
    chk("t6_rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("t6_rst_word_len", {26'd0, bus.word_len}, 32'd0);
    chk("t6_rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    chk("t6_rst_full", {31'd0, bus.full}, 32'd0);
    rx        = 1'b1;
    rst_n     = 1'b1;
    exp_q.delete();
    mq.delete();
    wl        = 0;
    prev_wend = 1'b0;
    repeat (40) @(negedge sysclk);
    send_byte(8'h7A, 1'b1, 1'b0, 1'b0);
    drain("t6");
    read_check("t6_rd");

`ifdef RX_PARITY_EN
    // parity error drops the byte
    do_reset();
    send_byte(8'h41, 1'b1, 1'b1, 1'b0);
    drain("tp");
    chk("tp_no_push", {31'd0, bus.empty}, 32'd1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
